// File: rtl/uart_game_pkg.sv
// rtl/uart_game_pkg.sv - shared frame definitions for the inter-board game link
//
// Purpose: one definition of the game-link frame (header, payload length,
// field widths and byte packing) shared by the transmit encoder and the
// receive parser, plus the receive FSM state type and the payload unpacker.
// Ports: none (package).
package uart_game_pkg;

  localparam logic [7:0] HEADER      = 8'hA5;
  localparam int         PAYLOAD_LEN = 9;

  localparam int POS_W     = 12;
  localparam int HP_W      = 4;
  localparam int BOSS_HP_W = 7;
  localparam int CLASS_W   = 2;

  // Payload byte indices (B0..B8)
  localparam int X_HI_BYTE      = 0;  // x[11:4]
  localparam int XY_BYTE        = 1;  // {x[3:0], y[11:8]}
  localparam int Y_LO_BYTE      = 2;  // y[7:0]
  localparam int HP_BYTE        = 3;  // {hp, aggro}
  localparam int BOSS_HP_BYTE   = 4;  // {flip_h, boss_hp}
  localparam int CLASS_BYTE     = 5;  // {class, 2'b00, boss_x[11:8]}
  localparam int BOSS_X_LO_BYTE = 6;  // boss_x[7:0]
  localparam int BOSS_Y_HI_BYTE = 7;  // boss_y[11:4]
  localparam int BOSS_Y_LO_BYTE = 8;  // {boss_y[3:0], 4'b0000}

  // Bit positions inside the shared bytes
  localparam int FLIP_BIT  = 7;
  localparam int CLASS_LSB = 6;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } frame_state_e;

  typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

  typedef struct packed {
    logic [POS_W-1:0]     p2_x;
    logic [POS_W-1:0]     p2_y;
    logic [HP_W-1:0]      p2_hp;
    logic [HP_W-1:0]      p2_aggro;
    logic [CLASS_W-1:0]   p2_class;
    logic                 p2_flip_h;
    logic [POS_W-1:0]     boss_x;
    logic [POS_W-1:0]     boss_y;
    logic [BOSS_HP_W-1:0] boss_hp;
  } game_frame_t;

  // Pad bits (CLASS_BYTE[5:4], BOSS_Y_LO_BYTE[3:0]) are deliberately ignored.
  function automatic game_frame_t unpack_frame(input payload_t p);
    game_frame_t f;
    f.p2_x      = {p[X_HI_BYTE], p[XY_BYTE][7:4]};
    f.p2_y      = {p[XY_BYTE][3:0], p[Y_LO_BYTE]};
    f.p2_hp     = p[HP_BYTE][7:4];
    f.p2_aggro  = p[HP_BYTE][3:0];
    f.p2_flip_h = p[BOSS_HP_BYTE][FLIP_BIT];
    f.boss_hp   = p[BOSS_HP_BYTE][BOSS_HP_W-1:0];
    f.p2_class  = p[CLASS_BYTE][CLASS_LSB +: CLASS_W];
    f.boss_x    = {p[CLASS_BYTE][3:0], p[BOSS_X_LO_BYTE]};
    f.boss_y    = {p[BOSS_Y_HI_BYTE], p[BOSS_Y_LO_BYTE][7:4]};
    return f;
  endfunction

endpackage

// File: rtl/uart_game_frame_rx.sv
// rtl/uart_game_frame_rx.sv - game-link frame parser on the UART RX FIFO
//
// Purpose: pops bytes from the RX FIFO, hunts for HEADER, collects the 9-byte
// payload and XOR checksum, and on a good checksum updates the remote player
// and boss outputs atomically. Also reports link health.
// Ports:
//   clk, rst              - system clock, asynchronous active-high reset
//   r_data, rx_empty      - RX FIFO head byte and empty flag
//   rd_uart               - FIFO pop, consumes r_data in the same cycle
//   player_2_*            - remote player state from the last good frame
//   boss_out_*            - remote boss state from the last good frame
//   frame_valid           - one-cycle strobe when the field outputs update
//   link_up               - a good frame was seen within LINK_TIMEOUT cycles
//   err_cnt               - saturating count of checksum errors and byte timeouts
module uart_game_frame_rx
  import uart_game_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 65000,
  parameter int unsigned LINK_TIMEOUT = 6500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           r_data,
  input  logic                 rx_empty,
  output logic                 rd_uart,
  output logic [POS_W-1:0]     player_2_x,
  output logic [POS_W-1:0]     player_2_y,
  output logic [HP_W-1:0]      player_2_hp,
  output logic [HP_W-1:0]      player_2_aggro,
  output logic [CLASS_W-1:0]   player_2_class,
  output logic                 player_2_flip_h,
  output logic [POS_W-1:0]     boss_out_x,
  output logic [POS_W-1:0]     boss_out_y,
  output logic [BOSS_HP_W-1:0] boss_out_hp,
  output logic                 frame_valid,
  output logic                 link_up,
  output logic [7:0]           err_cnt
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int LT_W = $clog2(LINK_TIMEOUT + 1);
  localparam logic [3:0]      LAST_IDX   = 4'(PAYLOAD_LEN - 1);
  localparam logic [BT_W-1:0] BT_LAST    = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [LT_W-1:0] LT_LAST    = LT_W'(LINK_TIMEOUT - 1);
  localparam logic [LT_W-1:0] LT_SAT     = LT_W'(LINK_TIMEOUT);

  frame_state_e    state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      chk_q, chk_d;
  payload_t        pay_q, pay_d;
  logic [BT_W-1:0] byte_tmr_q, byte_tmr_d;
  logic [LT_W-1:0] link_tmr_q, link_tmr_d;
  logic            link_up_q, link_up_d;
  logic            frame_valid_q, frame_valid_d;
  logic [7:0]      err_q, err_d;
  game_frame_t     fields_q, fields_d, unpacked;

  logic accept;
  logic good_frame;
  logic err_evt;

  assign accept  = !rx_empty;
  assign rd_uart = accept;

  assign unpacked = unpack_frame(pay_q);

  // Frame FSM and byte timer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    pay_d      = pay_q;
    byte_tmr_d = '0;
    good_frame = 1'b0;
    err_evt    = 1'b0;

    case (state_q)
      HUNT: begin
        if (accept && r_data == HEADER) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          pay_d[idx_q] = r_data;
          chk_d        = chk_q ^ r_data;
          idx_d        = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        // The checksum byte is always consumed here, so a mismatching byte
        // never gets a second look as a header.
        if (accept) begin
          state_d = HUNT;
          if (r_data == chk_q) begin
            good_frame = 1'b1;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // An accepted byte leaves byte_tmr_d at its zero default, so a byte in
    // the would-be timeout cycle wins over the timeout.
    if (state_q != HUNT && !accept) begin
      if (byte_tmr_q == BT_LAST) begin
        err_evt = 1'b1;
        state_d = HUNT;
      end else begin
        byte_tmr_d = byte_tmr_q + BT_W'(1);
      end
    end
  end

  // Outputs and link health
  always_comb begin
    fields_d      = good_frame ? unpacked : fields_q;
    frame_valid_d = good_frame;
    err_d         = (err_evt && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    link_tmr_d = link_tmr_q;
    link_up_d  = link_up_q;
    if (good_frame) begin
      link_tmr_d = '0;
      link_up_d  = 1'b1;
    end else begin
      if (link_tmr_q != LT_SAT) begin
        link_tmr_d = link_tmr_q + LT_W'(1);
      end
      if (link_tmr_q == LT_LAST) begin
        link_up_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      idx_q         <= '0;
      chk_q         <= '0;
      pay_q         <= '0;
      byte_tmr_q    <= '0;
      link_tmr_q    <= '0;
      link_up_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      err_q         <= '0;
      fields_q      <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      pay_q         <= pay_d;
      byte_tmr_q    <= byte_tmr_d;
      link_tmr_q    <= link_tmr_d;
      link_up_q     <= link_up_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
      fields_q      <= fields_d;
    end
  end

  assign player_2_x      = fields_q.p2_x;
  assign player_2_y      = fields_q.p2_y;
  assign player_2_hp     = fields_q.p2_hp;
  assign player_2_aggro  = fields_q.p2_aggro;
  assign player_2_class  = fields_q.p2_class;
  assign player_2_flip_h = fields_q.p2_flip_h;
  assign boss_out_x      = fields_q.boss_x;
  assign boss_out_y      = fields_q.boss_y;
  assign boss_out_hp     = fields_q.boss_hp;
  assign frame_valid     = frame_valid_q;
  assign link_up         = link_up_q;
  assign err_cnt         = err_q;

endmodule

// File: tb/tb_uart_game_frame_rx.sv
// tb/tb_uart_game_frame_rx.sv - self-checking bench for uart_game_frame_rx
module tb_uart_game_frame_rx;

  localparam int BT = 20;
  localparam int LT = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  r_data = 8'h00;
  logic        rx_empty = 1'b1;
  logic        rd_uart;
  logic [11:0] player_2_x, player_2_y, boss_out_x, boss_out_y;
  logic [3:0]  player_2_hp, player_2_aggro;
  logic [1:0]  player_2_class;
  logic        player_2_flip_h;
  logic [6:0]  boss_out_hp;
  logic        frame_valid, link_up;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  uart_game_frame_rx #(.BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
    .clk             (clk),
    .rst             (rst),
    .r_data          (r_data),
    .rx_empty        (rx_empty),
    .rd_uart         (rd_uart),
    .player_2_x      (player_2_x),
    .player_2_y      (player_2_y),
    .player_2_hp     (player_2_hp),
    .player_2_aggro  (player_2_aggro),
    .player_2_class  (player_2_class),
    .player_2_flip_h (player_2_flip_h),
    .boss_out_x      (boss_out_x),
    .boss_out_y      (boss_out_y),
    .boss_out_hp     (boss_out_hp),
    .frame_valid     (frame_valid),
    .link_up         (link_up),
    .err_cnt         (err_cnt)
  );

  wire [65:0] dut_f = {player_2_x, player_2_y, player_2_hp, player_2_aggro, player_2_class,
                       player_2_flip_h, boss_out_x, boss_out_y, boss_out_hp};

  function automatic logic [65:0] fld(input logic [11:0] x, input logic [11:0] y,
                                      input logic [3:0] hp, input logic [3:0] ag,
                                      input logic [1:0] cl, input logic fl,
                                      input logic [11:0] bx, input logic [11:0] by,
                                      input logic [6:0] bh);
    return {x, y, hp, ag, cl, fl, bx, by, bh};
  endfunction

  localparam logic [87:0] A_GOOD = 88'hA5_12_32_AB_53_E4_83_C0_1F_40_20;
  localparam logic [87:0] A_BAD  = 88'hA5_12_32_AB_53_E4_83_C0_1F_40_21;
  localparam logic [87:0] A_HCHK = 88'hA5_12_32_AB_53_E4_83_C0_1F_40_A5;
  localparam logic [87:0] B_GOOD = 88'hA5_FE_D0_01_A5_7F_4A_BC_00_00_03;
  localparam logic [87:0] B_BAD  = 88'hA5_FE_D0_01_A5_7F_4A_BC_00_00_04;
  localparam logic [87:0] C_GOOD = 88'hA5_12_32_AB_53_E4_B3_C0_1F_4F_1F;

  logic [65:0] f_a, f_b, f_zero;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Clock-cycle counter and frame_valid pulse monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int fv_cnt = 0, fv_last = 0, fv_prev = 0;
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt  = fv_cnt + 1;
      fv_prev = fv_last;
      fv_last = cyc;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_empty = 1'b0;
    r_data   = b;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_empty = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_part(input logic [87:0] s, input int first, input int last);
    for (int k = first; k <= last; k++) send(s[87-8*k -: 8]);
  endtask

  typedef struct {
    logic [87:0] bytes;
    logic        good;
    logic [65:0] f;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int exp_err;
    int base;
    int g;
    logic fell;

    f_a    = fld(12'h123, 12'h2AB, 4'h5, 4'h3, 2'd2, 1'b1, 12'h3C0, 12'h1F4, 7'h64);
    f_b    = fld(12'hFED, 12'h001, 4'hA, 4'h5, 2'd1, 1'b0, 12'hABC, 12'h000, 7'h7F);
    f_zero = '0;

    tbl[0] = '{A_BAD,  1'b0, f_a};
    tbl[1] = '{A_GOOD, 1'b1, f_a};
    tbl[2] = '{B_GOOD, 1'b1, f_b};
    tbl[3] = '{C_GOOD, 1'b1, f_a};
    tbl[4] = '{B_BAD,  1'b0, f_a};
    tbl[5] = '{B_GOOD, 1'b1, f_b};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_fields", 80'(dut_f), 80'(f_zero));
    check("reset_fv", 80'(frame_valid), 80'(0));
    check("reset_link", 80'(link_up), 80'(0));
    check("reset_err", 80'(err_cnt), 80'(0));
    check("rd_uart_empty", 80'(rd_uart), 80'(0));
    rst = 1'b0;
    @(negedge clk);
    rx_empty = 1'b0;
    r_data   = 8'h00;
    #1;
    check("rd_uart_nonempty", 80'(rd_uart), 80'(1));

    // Junk then a good frame
    send(8'hFF);
    send(8'h13);
    send_part(A_GOOD, 0, 10);
    idle(1);
    check("junk_fv", 80'(frame_valid), 80'(1));
    check("junk_fields", 80'(dut_f), 80'(f_a));
    check("junk_err", 80'(err_cnt), 80'(0));
    check("junk_link", 80'(link_up), 80'(1));
    idle(1);
    check("junk_fv_pulse", 80'(frame_valid), 80'(0));
    exp_err = 0;

    // Table of whole frames
    for (int i = 0; i < 6; i++) begin
      send_part(tbl[i].bytes, 0, 10);
      idle(1);
      if (!tbl[i].good) exp_err++;
      check($sformatf("tbl%0d_fv", i), 80'(frame_valid), 80'(tbl[i].good));
      check($sformatf("tbl%0d_fields", i), 80'(dut_f), 80'(tbl[i].f));
      check($sformatf("tbl%0d_err", i), 80'(err_cnt), 80'(exp_err));
      if (tbl[i].good) check($sformatf("tbl%0d_link", i), 80'(link_up), 80'(1));
      idle(1);
      check($sformatf("tbl%0d_fv_end", i), 80'(frame_valid), 80'(0));
    end

    // Mismatching checksum byte equal to HEADER is not a resync
    #1 base = fv_cnt;
    send_part(A_HCHK, 0, 10);
    send_part(A_GOOD, 1, 10);
    idle(2);
    exp_err++;
    #1;
    check("hdrchk_no_fv", 80'(fv_cnt - base), 80'(0));
    check("hdrchk_err", 80'(err_cnt), 80'(exp_err));
    check("hdrchk_fields", 80'(dut_f), 80'(f_b));

    // Byte timeout: stall BT cycles after B4
    #1 base = fv_cnt;
    send_part(A_GOOD, 0, 5);
    idle(BT + 1);
    exp_err++;
    check("tmo_err", 80'(err_cnt), 80'(exp_err));
    send_part(A_GOOD, 6, 10);
    idle(2);
    #1;
    check("tmo_no_fv", 80'(fv_cnt - base), 80'(0));
    check("tmo_fields", 80'(dut_f), 80'(f_b));
    check("tmo_err_after", 80'(err_cnt), 80'(exp_err));

    // Stall BT-1 cycles: byte wins
    send_part(A_GOOD, 0, 5);
    idle(BT - 1);
    send_part(A_GOOD, 6, 10);
    idle(1);
    check("tmo1_fv", 80'(frame_valid), 80'(1));
    check("tmo1_fields", 80'(dut_f), 80'(f_a));
    check("tmo1_err", 80'(err_cnt), 80'(exp_err));

    // Back-to-back frames with no bubbles
    idle(2);
    #1 base = fv_cnt;
    send_part(A_GOOD, 0, 10);
    send_part(B_GOOD, 0, 10);
    idle(3);
    #1;
    check("b2b_count", 80'(fv_cnt - base), 80'(2));
    check("b2b_spacing", 80'(fv_last - fv_prev), 80'(11));
    check("b2b_fields", 80'(dut_f), 80'(f_b));
    check("b2b_link", 80'(link_up), 80'(1));

    // Link timeout
    g = fv_last;
    fell = 1'b0;
    for (int k = 0; k < LT + 50 && !fell; k++) begin
      @(negedge clk);
      if (link_up === 1'b0) fell = 1'b1;
    end
    check("link_fell", 80'(fell), 80'(1));
    check("link_delay", 80'(cyc - g), 80'(LT));

    // Asynchronous reset mid-frame
    #1 base = fv_cnt;
    send_part(A_GOOD, 0, 4);
    @(negedge clk);
    rx_empty = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_fields", 80'(dut_f), 80'(f_zero));
    check("arst_err", 80'(err_cnt), 80'(0));
    check("arst_link", 80'(link_up), 80'(0));
    @(negedge clk);
    rst = 1'b0;
    send_part(A_GOOD, 5, 10);
    idle(2);
    #1;
    check("arst_no_fv", 80'(fv_cnt - base), 80'(0));
    check("arst_fields_after", 80'(dut_f), 80'(f_zero));
    check("arst_err_after", 80'(err_cnt), 80'(0));

    // Error counter saturation
    for (int i = 0; i < 255; i++) send_part(A_BAD, 0, 10);
    idle(1);
    check("sat_255", 80'(err_cnt), 80'(255));
    send_part(A_BAD, 0, 10);
    idle(1);
    check("sat_hold", 80'(err_cnt), 80'(255));
    check("sat_fields", 80'(dut_f), 80'(f_zero));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_game_frame_rx.md
Name: uart_game_frame_rx

Overview:
Receive-side frame parser for the inter-board game link. It pops bytes from the UART RX FIFO, hunts for the frame header, and collects a fixed 9-byte payload plus an XOR checksum. Each frame carries the remote player state and its boss state. On a good checksum it atomically updates registered player_2/boss_out outputs for top_vga. It also provides link-health status: a frame strobe, a link-up flag and a saturating error count.

Parameters:
HEADER, 8'hA5, frame start byte
BYTE_TIMEOUT, 65000, max clk cycles between bytes inside a frame (1 ms at 65 MHz)
LINK_TIMEOUT, 6500000, cycles without a good frame before link_up drops (100 ms)

Ports:
clk  in  1  65 MHz system clock
rst  in  1  asynchronous, active-high reset
r_data  in  8  RX FIFO head byte, valid while rx_empty=0
rx_empty  in  1  RX FIFO empty flag
rd_uart  out  1  FIFO pop; the byte on r_data is consumed in the same cycle
player_2_x, player_2_y  out  12 each  remote player position
player_2_hp, player_2_aggro  out  4 each  remote health and aggro
player_2_class  out  2  remote class
player_2_flip_h  out  1  remote sprite mirror
boss_out_x, boss_out_y  out  12 each  remote boss position
boss_out_hp  out  7  remote boss health
frame_valid  out  1  one-cycle strobe when outputs are updated
link_up  out  1  good frame seen within LINK_TIMEOUT
err_cnt  out  8  saturating count of checksum errors plus byte timeouts

Behaviour:
- Reset: all outputs 0; state HUNT; index, checksum and timers 0. An asserted rst aborts any partial frame. Field outputs keep no stale data.
- rd_uart = !rx_empty (combinational). Exactly one byte is accepted per cycle in which rd_uart=1.
- Frame format: HEADER, B0..B8, CHK, where CHK = B0^…^B8. Byte packing:
  - B0 = x[11:4]
  - B1 = {x[3:0], y[11:8]}
  - B2 = y[7:0]
  - B3 = {hp, aggro}
  - B4 = {flip_h, boss_hp[6:0]}
  - B5 = {class, 2'b00, boss_x[11:8]}
  - B6 = boss_x[7:0]
  - B7 = boss_y[11:4]
  - B8 = {boss_y[3:0], 4'b0000}
  - Pad bits are ignored on receive.
- FSM:
  - HUNT: on accepted byte == HEADER, go to PAYLOAD with idx=0, chk=0. Other bytes are discarded silently.
  - PAYLOAD: on accepted byte, buf[idx] <= byte, chk ^= byte, idx++. At idx==8, go to CHECK.
  - CHECK: on accepted byte == chk, all fields load from buf in one cycle and frame_valid=1 on the next cycle edge (one cycle after the CHK byte is accepted); the link timer clears; go to HUNT. On mismatch, err_cnt++ (saturates at 255), outputs are unchanged, go to HUNT. The mismatching byte is not re-examined as a header.
- Byte timer: runs only in PAYLOAD/CHECK and clears on each accepted byte. When it reaches BYTE_TIMEOUT, err_cnt++ and the FSM goes to HUNT. If a byte arrives in the same cycle the timeout would fire, the byte wins and there is no error.
- Link timer: saturating counter. link_up=1 from the frame_valid cycle until LINK_TIMEOUT cycles pass without another good frame.
- Outputs are never partially updated. A field set belongs to exactly one frame.
- Back-to-back frames with rx_empty=0 continuously are accepted at one byte per cycle with no bubbles.

Decomposition:
- Shared package uart_game_pkg holds:
  - the HEADER value
  - PAYLOAD_LEN=9
  - the frame state enum {HUNT, PAYLOAD, CHECK}
  - field-width localparams (POS_W=12, HP_W=4, BOSS_HP_W=7, CLASS_W=2)
  - the byte-packing bit positions, so the transmit-side encoder and this block use one definition.
- No sub-module. The unpack is a single combinational assignment inside the block.

Test Plan:
- Good frame: A5 12 32 AB 53 E4 83 C0 1F 40 20 -> x=0x123, y=0x2AB, hp=5, aggro=3, flip_h=1, boss_hp=0x64, class=2, boss_x=0x3C0, boss_y=0x1F4; one frame_valid pulse; link_up=1; err_cnt=0.
- Same frame with CHK=0x21 -> outputs unchanged, no frame_valid, err_cnt=1. A following correct frame then updates normally.
- Junk bytes 00 FF 13 before a good frame -> junk ignored, frame decoded, err_cnt=0. A header byte value (0xA5) inside the payload is stored as data, not treated as a resync.
- Stall BYTE_TIMEOUT cycles after B4 -> err_cnt=1, state HUNT. A byte arriving at exactly timeout-1 cycles is accepted with no error.
- Two good frames back-to-back with rx_empty held low -> two frame_valid pulses 11 cycles apart. No frame for LINK_TIMEOUT cycles -> link_up falls.
- Assert rst after B3 of a frame -> all outputs 0 asynchronously. The rest of that frame is ignored until a new HEADER arrives; 256 bad frames -> err_cnt stays at 255.
